// File: rtl/mult_issue_sequencer_if.sv
// Handshake bundle between the operand producer, the issue sequencer,
// the downstream sequential multiplier and the result consumer.
interface mult_issue_sequencer_if #(
    parameter int WIDTH = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_multiplicand;
    logic [WIDTH-1:0]     in_multiplier;
    logic                 mul_start;
    logic [WIDTH-1:0]     mul_multiplicand;
    logic [WIDTH-1:0]     mul_multiplier;
    logic                 mul_ready;
    logic [2*WIDTH-1:0]   mul_product;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_product;
    logic [7:0]           done_count;

    modport slave (
        input  in_valid, in_multiplicand, in_multiplier, mul_ready, mul_product, out_ready,
        output in_ready, mul_start, mul_multiplicand, mul_multiplier, out_valid, out_product,
               done_count
    );

    modport master (
        output in_valid, in_multiplicand, in_multiplier, mul_ready, mul_product, out_ready,
        input  in_ready, mul_start, mul_multiplicand, mul_multiplier, out_valid, out_product,
               done_count
    );
endinterface

// File: rtl/mult_issue_sequencer.sv
// Queues operand pairs and feeds them one at a time to a sequential multiplier,
// holding each product until the consumer takes it.
module mult_issue_sequencer #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    mult_issue_sequencer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] mcand;
        logic [WIDTH-1:0] mplier;
    } pair_t;

    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, HOLD} state_t;

    state_t             state, state_nxt;
    pair_t              mem [DEPTH];
    logic [AW:0]        wr_ptr, rd_ptr;
    logic               full, empty, push, pop;
    logic [WIDTH-1:0]   op_a, op_b;
    logic [2*WIDTH-1:0] prod_q;
    logic [7:0]         done_q;

    // Extra pointer bit tells full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign bus.in_ready = !full && !reset;
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = (state == IDLE) && !empty && bus.mul_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (pop) state_nxt = START;
            START:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (!bus.mul_ready) state_nxt = WAIT_DONE;
            WAIT_DONE: if (bus.mul_ready) state_nxt = HOLD;
            HOLD:      if (bus.out_ready) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= '{mcand: bus.in_multiplicand, mplier: bus.in_multiplier};
    end

    // Operands load only on pop, so they stay put for the whole run.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_a   <= '0;
            op_b   <= '0;
            prod_q <= '0;
            done_q <= '0;
        end else begin
            if (pop) begin
                op_a <= mem[rd_ptr[AW-1:0]].mcand;
                op_b <= mem[rd_ptr[AW-1:0]].mplier;
            end
            if (state == WAIT_DONE && bus.mul_ready) prod_q <= bus.mul_product;
            if (state == HOLD && bus.out_ready)      done_q <= done_q + 8'd1;
        end
    end

    assign bus.mul_start        = (state == START);
    assign bus.mul_multiplicand = op_a;
    assign bus.mul_multiplier   = op_b;
    assign bus.out_valid        = (state == HOLD);
    assign bus.out_product      = prod_q;
    assign bus.done_count       = done_q;
endmodule

// File: tb/tb_mult_issue_sequencer.sv
// Directed bench for mult_issue_sequencer with a small sequential-multiplier model.
module tb_mult_issue_sequencer;
    localparam int W = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   starts = 0;

    mult_issue_sequencer_if #(.WIDTH(W)) bus ();

    mult_issue_sequencer #(.WIDTH(W), .DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Multiplier model: busy for three cycles after a start pulse, stallable.
    logic [3:0]     mcnt  = '0;
    logic [W-1:0]   ma    = '0;
    logic [W-1:0]   mb    = '0;
    logic [2*W-1:0] mprod = '0;
    logic           stall = 1'b0;

    always @(posedge clock) begin
        if (bus.mul_start) begin
            ma   <= bus.mul_multiplicand;
            mb   <= bus.mul_multiplier;
            mcnt <= 4'd3;
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 4'd1;
            if (mcnt == 4'd1) mprod <= ma * mb;
        end
        if (bus.mul_start) starts <= starts + 1;
    end

    assign bus.mul_ready   = (mcnt == 0) && !stall;
    assign bus.mul_product = mprod;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int i = 0; i < 100 && !bus.in_ready; i++) step();
        chk("push_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid        = 1'b1;
        bus.in_multiplicand = a;
        bus.in_multiplier   = b;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [2*W-1:0] exp);
        for (int i = 0; i < 60 && !bus.out_valid; i++) step();
        chk("out_valid_timeout", {31'd0, bus.out_valid}, 32'd1);
        chk(tag, {22'd0, bus.out_product}, {22'd0, exp});
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("out_valid_drop", {31'd0, bus.out_valid}, 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mul_start"}, {31'd0, bus.mul_start}, 32'd0);
        chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_out_product"}, {22'd0, bus.out_product}, 32'd0);
        chk({tag, "_mcand"}, {27'd0, bus.mul_multiplicand}, 32'd0);
        chk({tag, "_mplier"}, {27'd0, bus.mul_multiplier}, 32'd0);
        chk({tag, "_done_count"}, {24'd0, bus.done_count}, 32'd0);
    endtask

    initial begin
        int s0;
        logic [W-1:0] a;
        bus.in_valid        = 1'b0;
        bus.in_multiplicand = '0;
        bus.in_multiplier   = '0;
        bus.out_ready       = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk_reset_vals("rst");
        reset = 1'b0;
        #1;
        chk("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // (3,3): start two cycles after push, single pulse, product 9
        s0 = starts;
        bus.in_valid        = 1'b1;
        bus.in_multiplicand = 5'd3;
        bus.in_multiplier   = 5'd3;
        step();
        bus.in_valid = 1'b0;
        chk("lat_t1_start", {31'd0, bus.mul_start}, 32'd0);
        step();
        chk("lat_t2_start", {31'd0, bus.mul_start}, 32'd1);
        chk("t1_mcand", {27'd0, bus.mul_multiplicand}, 32'd3);
        chk("t1_mplier", {27'd0, bus.mul_multiplier}, 32'd3);
        get_result("t1_product", 10'b0000001001);
        chk("t1_starts", starts - s0, 32'd1);
        chk("t1_done", {24'd0, bus.done_count}, 32'd1);

        // (31,31): operands stable from START until the result
        push(5'd31, 5'd31);
        for (int i = 0; i < 20 && !bus.mul_start; i++) step();
        chk("t2_start_seen", {31'd0, bus.mul_start}, 32'd1);
        for (int i = 0; i < 30 && !bus.out_valid; i++) begin
            chk("t2_mcand_stable", {27'd0, bus.mul_multiplicand}, 32'd31);
            chk("t2_mplier_stable", {27'd0, bus.mul_multiplier}, 32'd31);
            step();
        end
        get_result("t2_product", 10'b1111000001);
        chk("t2_done", {24'd0, bus.done_count}, 32'd2);

        // Fill the FIFO with the multiplier stalled
        stall = 1'b1;
        s0 = starts;
        push(5'd1, 5'd2);
        push(5'd3, 5'd4);
        push(5'd5, 5'd6);
        chk("fill3_in_ready", {31'd0, bus.in_ready}, 32'd1);
        push(5'd7, 5'd8);
        chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.in_valid        = 1'b1;
        bus.in_multiplicand = 5'd9;
        bus.in_multiplier   = 5'd10;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full_held_off", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.in_valid = 1'b0;
        chk("stall_no_start", starts - s0, 32'd0);
        stall = 1'b0;

        // First result held 10 cycles; FIFO refills meanwhile
        for (int i = 0; i < 60 && !bus.out_valid; i++) step();
        chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
        s0 = starts;
        chk("hold_space", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid        = 1'b1;
        bus.in_multiplicand = 5'd9;
        bus.in_multiplier   = 5'd10;
        step();
        bus.in_valid = 1'b0;
        chk("hold_refull", {31'd0, bus.in_ready}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            chk("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("hold_product", {22'd0, bus.out_product}, 32'd2);
            step();
        end
        chk("hold_no_start", starts - s0, 32'd0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        get_result("ord_12", 10'd12);
        get_result("ord_30", 10'd30);
        get_result("ord_56", 10'd56);
        get_result("ord_90", 10'd90);
        chk("ord_done", {24'd0, bus.done_count}, 32'd7);

        // Reset during WAIT_DONE with two pairs queued
        s0 = starts;
        push(5'd2, 5'd2);
        push(5'd4, 5'd4);
        push(5'd6, 5'd6);
        chk("mr_start_seen", starts - s0, 32'd1);
        chk("mr_mul_busy", {31'd0, bus.mul_ready}, 32'd0);
        step();
        reset = 1'b1;
        #1;
        chk("mr_in_ready_rst", {31'd0, bus.in_ready}, 32'd0);
        step();
        chk_reset_vals("mr");
        reset = 1'b0;
        s0 = starts;
        for (int i = 0; i < 20; i++) step();
        chk("mr_no_start", starts - s0, 32'd0);
        chk("mr_no_result", {31'd0, bus.out_valid}, 32'd0);
        chk("mr_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("mr_out_product", {22'd0, bus.out_product}, 32'd0);

        // done_count wrap: 255 then 0
        for (int i = 0; i < 255; i++) begin
            a = i[W-1:0];
            push(a, 5'd7);
            get_result("loop_product", {5'd0, a} * 10'd7);
        end
        chk("wrap_255", {24'd0, bus.done_count}, 32'd255);
        push(5'd17, 5'd19);
        get_result("wrap_product", 10'd323);
        chk("wrap_0", {24'd0, bus.done_count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
